commit_store_queue: RTL and testbench

Unified speculative/committed store queue between the LSU store unit and the data cache. It holds executed but uncommitted stores, and it holds stores that the commit stage has retired, then drains the retired ones to the D$ in program order. It produces the commit stage's `commit_lsu_ready_i` and `no_st_pending_i` inputs and consumes its `commit_lsu_o`. One circular buffer with three pointers replaces the separate speculative and commit queues.

---
 rtl/commit_store_queue_pkg.sv | 12 +
 rtl/commit_store_queue_if.sv | 35 +++
 rtl/commit_store_queue.sv | 83 ++++++++
 tb/tb_commit_store_queue.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/commit_store_queue_pkg.sv
// Shared widths and the store queue entry type used by the store queue and its bench.
package commit_store_queue_pkg;
    localparam int unsigned PLEN = 56;
    localparam int unsigned XLEN = 64;

    typedef struct packed {
        logic [PLEN-1:0]   paddr;
        logic [XLEN-1:0]   data;
        logic [XLEN/8-1:0] be;
        logic [1:0]        size;
    } store_q_entry_t;
endpackage

// File: rtl/commit_store_queue_if.sv
// Store-unit, commit-stage and D$ signals of the store queue; slave is the queue's view.
interface commit_store_queue_if;
    import commit_store_queue_pkg::*;

    logic              flush_i;
    logic              valid_i;
    logic              ready_o;
    logic [PLEN-1:0]   paddr_i;
    logic [XLEN-1:0]   data_i;
    logic [XLEN/8-1:0] be_i;
    logic [1:0]        size_i;
    logic              commit_i;
    logic              commit_ready_o;
    logic              no_st_pending_o;
    logic [11:0]       page_offset_i;
    logic              page_offset_matches_o;
    logic              req_o;
    logic [PLEN-1:0]   addr_o;
    logic [XLEN-1:0]   wdata_o;
    logic [XLEN/8-1:0] be_o;
    logic [1:0]        size_o;
    logic              gnt_i;

    modport slave (
        input  flush_i, valid_i, paddr_i, data_i, be_i, size_i, commit_i, page_offset_i, gnt_i,
        output ready_o, commit_ready_o, no_st_pending_o, page_offset_matches_o,
        output req_o, addr_o, wdata_o, be_o, size_o
    );

    modport master (
        output flush_i, valid_i, paddr_i, data_i, be_i, size_i, commit_i, page_offset_i, gnt_i,
        input  ready_o, commit_ready_o, no_st_pending_o, page_offset_matches_o,
        input  req_o, addr_o, wdata_o, be_o, size_o
    );
endinterface

// File: rtl/commit_store_queue.sv
// Unified speculative/committed store queue: one ring, three pointers
// (rd = oldest committed, cm = oldest speculative, wr = next free), drained to the D$ in order.
module commit_store_queue
    import commit_store_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    commit_store_queue_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    typedef logic [PW-1:0] ptr_t;
    typedef logic [PW:0]   cnt_t;

    store_q_entry_t mem [DEPTH];
    ptr_t rd_ptr, cm_ptr, wr_ptr;
    cnt_t spec_cnt, cmt_cnt, occ;
    logic do_wr, do_cm, do_dr, match;
    logic unused_offset_bits;

    assign occ   = spec_cnt + cmt_cnt;
    // A write racing a flush is dropped, so it never lands past the new wr_ptr.
    assign do_wr = bus.valid_i && bus.ready_o && !bus.flush_i;
    assign do_cm = bus.commit_i && (spec_cnt != '0);
    assign do_dr = bus.req_o && bus.gnt_i;

    assign bus.ready_o         = (occ != cnt_t'(DEPTH));
    assign bus.commit_ready_o  = (spec_cnt != '0);
    assign bus.no_st_pending_o = (cmt_cnt == '0);
    assign bus.req_o           = (cmt_cnt != '0);
    assign bus.addr_o          = mem[rd_ptr].paddr;
    assign bus.wdata_o         = mem[rd_ptr].data;
    assign bus.be_o            = mem[rd_ptr].be;
    assign bus.size_o          = mem[rd_ptr].size;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr   <= '0;
            cm_ptr   <= '0;
            wr_ptr   <= '0;
            spec_cnt <= '0;
            cmt_cnt  <= '0;
        end else begin
            rd_ptr  <= rd_ptr + ptr_t'(do_dr);
            cm_ptr  <= cm_ptr + ptr_t'(do_cm);
            cmt_cnt <= cmt_cnt + cnt_t'(do_cm) - cnt_t'(do_dr);
            if (bus.flush_i) begin
                wr_ptr   <= cm_ptr + ptr_t'(do_cm);
                spec_cnt <= '0;
            end else begin
                wr_ptr   <= wr_ptr + ptr_t'(do_wr);
                spec_cnt <= spec_cnt + cnt_t'(do_wr) - cnt_t'(do_cm);
            end
        end
    end

    // Entry storage carries no reset; occupancy is defined purely by the counters.
    always_ff @(posedge clk_i) begin
        if (do_wr && !rst_i)
            mem[wr_ptr] <= '{paddr: bus.paddr_i, data: bus.data_i, be: bus.be_i, size: bus.size_i};
    end

    // Slot i is occupied when its distance from rd_ptr is below the total occupancy.
    always_comb begin
        match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (({1'b0, ptr_t'(ptr_t'(i) - rd_ptr)} < occ) &&
                (mem[i].paddr[11:3] == bus.page_offset_i[11:3]))
                match = 1'b1;
        end
    end
    assign bus.page_offset_matches_o = match;
    assign unused_offset_bits = ^bus.page_offset_i[2:0];

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!rst_i)
            assert (({1'b0, spec_cnt} + {1'b0, cmt_cnt}) <= (PW + 2)'(DEPTH))
            else $error("store queue occupancy exceeds DEPTH");
    end
`endif
endmodule

// File: tb/tb_commit_store_queue.sv
// Directed bench with a queue-level reference model checked on every falling edge.
module tb_commit_store_queue;
    import commit_store_queue_pkg::*;
    localparam int DEPTH = 8;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    commit_store_queue_if bus ();
    commit_store_queue #(.DEPTH(DEPTH)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

    int checks = 0;
    int fails  = 0;
    int drained = 0;
    bit model_on = 0;
    store_q_entry_t spec_q[$];
    store_q_entry_t cmt_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_wr(input logic v, input logic [PLEN-1:0] a, input logic [XLEN-1:0] d);
        bus.valid_i = v;
        bus.paddr_i = a;
        bus.data_i  = d;
        bus.be_i    = 8'h0F;
        bus.size_i  = 2'd2;
    endtask

    // Reference model: outputs compared before the update the next rising edge will apply.
    always @(negedge clk_i) begin
        int occ;
        bit hz;
        store_q_entry_t e;
        if (model_on) begin
            occ = spec_q.size() + cmt_q.size();
            hz = 0;
            foreach (spec_q[i]) if (spec_q[i].paddr[11:3] == bus.page_offset_i[11:3]) hz = 1;
            foreach (cmt_q[i])  if (cmt_q[i].paddr[11:3] == bus.page_offset_i[11:3]) hz = 1;
            chk("ready", 64'(bus.ready_o), 64'(occ < DEPTH));
            chk("commit_ready", 64'(bus.commit_ready_o), 64'(spec_q.size() != 0));
            chk("req", 64'(bus.req_o), 64'(cmt_q.size() != 0));
            chk("no_st_pending", 64'(bus.no_st_pending_o), 64'(cmt_q.size() == 0));
            chk("match", 64'(bus.page_offset_matches_o), 64'(hz));
            if (cmt_q.size() != 0) begin
                chk("addr", 64'(bus.addr_o), 64'(cmt_q[0].paddr));
                chk("wdata", bus.wdata_o, cmt_q[0].data);
                chk("be", 64'(bus.be_o), 64'(cmt_q[0].be));
                chk("size", 64'(bus.size_o), 64'(cmt_q[0].size));
            end
        end
        if (rst_i) begin
            spec_q.delete();
            cmt_q.delete();
            model_on = 1;
        end else if (model_on) begin
            occ = spec_q.size() + cmt_q.size();
            if (cmt_q.size() != 0 && bus.gnt_i) begin
                void'(cmt_q.pop_front());
                drained++;
            end
            if (bus.commit_i && spec_q.size() != 0) begin
                e = spec_q.pop_front();
                cmt_q.push_back(e);
            end
            if (bus.flush_i) spec_q.delete();
            else if (bus.valid_i && occ < DEPTH)
                spec_q.push_back('{paddr: bus.paddr_i, data: bus.data_i, be: bus.be_i, size: bus.size_i});
        end
    end

    initial begin
        int d0;
        bus.flush_i = 0; bus.commit_i = 0; bus.gnt_i = 0; bus.page_offset_i = '0;
        set_wr(0, '0, '0);
        repeat (2) cyc();
        rst_i = 0;
        cyc();
        chk("rst_ready", 64'(bus.ready_o), 64'd1);
        chk("rst_req", 64'(bus.req_o), 64'd0);

        // single store, immediate grant
        bus.gnt_i = 1;
        set_wr(1, 56'h8000_0010, 64'hDEAD_BEEF);
        cyc();
        set_wr(0, '0, '0);
        chk("t1_commit_ready", 64'(bus.commit_ready_o), 64'd1);
        chk("t1_nsp_before", 64'(bus.no_st_pending_o), 64'd1);
        bus.commit_i = 1;
        cyc();
        bus.commit_i = 0;
        chk("t1_req", 64'(bus.req_o), 64'd1);
        chk("t1_nsp", 64'(bus.no_st_pending_o), 64'd0);
        chk("t1_addr", 64'(bus.addr_o), 64'h8000_0010);
        chk("t1_data", bus.wdata_o, 64'hDEAD_BEEF);
        cyc();
        chk("t1_req_done", 64'(bus.req_o), 64'd0);
        chk("t1_nsp_after", 64'(bus.no_st_pending_o), 64'd1);

        // fill and drain
        bus.gnt_i = 0;
        for (int i = 0; i < DEPTH; i++) begin
            set_wr(1, 56'h8000_1000 + 56'(i * 8), 64'h1111_0000 + 64'(i));
            cyc();
        end
        set_wr(0, '0, '0);
        chk("t2_full", 64'(bus.ready_o), 64'd0);
        bus.commit_i = 1;
        repeat (DEPTH) cyc();
        bus.commit_i = 0;
        repeat (3) cyc();
        chk("t2_held_req", 64'(bus.req_o), 64'd1);
        chk("t2_held_addr", 64'(bus.addr_o), 64'h8000_1000);
        d0 = drained;
        bus.gnt_i = 1;
        for (int k = 0; k < 40 && !bus.no_st_pending_o; k++) cyc();
        chk("t2_drained", 64'(drained - d0), 64'd8);
        chk("t2_req_off", 64'(bus.req_o), 64'd0);
        chk("t2_nsp", 64'(bus.no_st_pending_o), 64'd1);

        // flush keeps committed entries
        bus.gnt_i = 0;
        for (int i = 0; i < 3; i++) begin
            set_wr(1, 56'h8000_2000 + 56'(i * 8), 64'h2222_0000 + 64'(i));
            cyc();
        end
        set_wr(0, '0, '0);
        bus.commit_i = 1; bus.flush_i = 1;
        cyc();
        bus.commit_i = 0; bus.flush_i = 0;
        chk("t3_commit_ready", 64'(bus.commit_ready_o), 64'd0);
        chk("t3_req", 64'(bus.req_o), 64'd1);
        d0 = drained;
        bus.gnt_i = 1;
        repeat (5) cyc();
        chk("t3_one_drain", 64'(drained - d0), 64'd1);
        set_wr(1, 56'h8000_2100, 64'h2222_00FF);
        cyc();
        set_wr(0, '0, '0);
        bus.commit_i = 1;
        cyc();
        bus.commit_i = 0;
        chk("t3_next_addr", 64'(bus.addr_o), 64'h8000_2100);
        repeat (3) cyc();

        // write during flush is dropped
        set_wr(1, 56'h8000_3000, 64'h3333);
        bus.flush_i = 1;
        cyc();
        set_wr(0, '0, '0);
        bus.flush_i = 0;
        chk("t4_commit_ready", 64'(bus.commit_ready_o), 64'd0);
        chk("t4_ready", 64'(bus.ready_o), 64'd1);

        // hazard check
        bus.gnt_i = 0;
        set_wr(1, 56'h8000_4108, 64'h4444_0001);
        cyc();
        set_wr(1, 56'h8000_47F0, 64'h4444_0002);
        cyc();
        set_wr(0, '0, '0);
        bus.page_offset_i = 12'h10C;
        #1 chk("t5_match_hit", 64'(bus.page_offset_matches_o), 64'd1);
        bus.page_offset_i = 12'h110;
        #1 chk("t5_match_miss", 64'(bus.page_offset_matches_o), 64'd0);
        bus.page_offset_i = 12'h7F4;
        cyc();

        // reset mid-drain
        bus.commit_i = 1;
        cyc();
        bus.commit_i = 0;
        chk("t6_req_busy", 64'(bus.req_o), 64'd1);
        chk("t6_match_busy", 64'(bus.page_offset_matches_o), 64'd1);
        rst_i = 1;
        cyc();
        rst_i = 0;
        chk("t6_ready", 64'(bus.ready_o), 64'd1);
        chk("t6_nsp", 64'(bus.no_st_pending_o), 64'd1);
        chk("t6_commit_ready", 64'(bus.commit_ready_o), 64'd0);
        chk("t6_req", 64'(bus.req_o), 64'd0);
        chk("t6_match", 64'(bus.page_offset_matches_o), 64'd0);

        // back-to-back write/commit/drain across the pointer wrap
        d0 = drained;
        bus.gnt_i = 1; bus.commit_i = 1;
        for (int i = 0; i < 20; i++) begin
            set_wr(1, 56'h8000_5000 + 56'(i * 8), 64'h5555_0000 + 64'(i));
            cyc();
        end
        set_wr(0, '0, '0);
        for (int k = 0; k < 20 && (drained - d0) < 20; k++) cyc();
        bus.commit_i = 0;
        chk("t7_drained", 64'(drained - d0), 64'd20);
        chk("t7_nsp", 64'(bus.no_st_pending_o), 64'd1);
        cyc();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
